decade_ring_check: RTL and testbench



---
 rtl/decade_ring_pkg.sv | 47 ++++
 rtl/two_of_five_decode.sv | 17 +
 rtl/decade_ring_check.sv | 128 ++++++++++++
 tb/tb_decade_ring_check.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/decade_ring_pkg.sv
// Shared definitions for the 2-of-5 buffer-ring decade counter and its checkers.
package decade_ring_pkg;

  localparam int unsigned CODE_W  = 5;
  localparam int unsigned DIGIT_W = 4;

  // Ring code {a,b,c,d,e} for each decimal digit
  localparam logic [CODE_W-1:0] CODE_D0 = 5'b00011;
  localparam logic [CODE_W-1:0] CODE_D1 = 5'b10010;
  localparam logic [CODE_W-1:0] CODE_D2 = 5'b10001;
  localparam logic [CODE_W-1:0] CODE_D3 = 5'b01001;
  localparam logic [CODE_W-1:0] CODE_D4 = 5'b11000;
  localparam logic [CODE_W-1:0] CODE_D5 = 5'b10100;
  localparam logic [CODE_W-1:0] CODE_D6 = 5'b01100;
  localparam logic [CODE_W-1:0] CODE_D7 = 5'b01010;
  localparam logic [CODE_W-1:0] CODE_D8 = 5'b00110;
  localparam logic [CODE_W-1:0] CODE_D9 = 5'b00101;

  localparam logic [DIGIT_W-1:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_e;

  function automatic logic [DIGIT_W-1:0] inc_mod10(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(9)) ? '0 : d + DIGIT_W'(1);
  endfunction

  function automatic logic [DIGIT_W-1:0] code_to_digit(input logic [CODE_W-1:0] c);
    case (c)
      CODE_D0: return DIGIT_W'(0);
      CODE_D1: return DIGIT_W'(1);
      CODE_D2: return DIGIT_W'(2);
      CODE_D3: return DIGIT_W'(3);
      CODE_D4: return DIGIT_W'(4);
      CODE_D5: return DIGIT_W'(5);
      CODE_D6: return DIGIT_W'(6);
      CODE_D7: return DIGIT_W'(7);
      CODE_D8: return DIGIT_W'(8);
      CODE_D9: return DIGIT_W'(9);
      default: return DIGIT_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/two_of_five_decode.sv
// Combinational 2-of-5 ring code to BCD decoder; digit is 4'hF when the code is invalid.
module two_of_five_decode
  import decade_ring_pkg::*;
(
  input  logic [CODE_W-1:0]  i_code,
  output logic [DIGIT_W-1:0] o_digit_c,
  output logic               o_valid_c
);

  logic [2:0] ones_c;

  // Every one of the ten 2-hot patterns is a digit, so a popcount of two is validity
  assign ones_c    = 3'(i_code[0]) + 3'(i_code[1]) + 3'(i_code[2]) + 3'(i_code[3]) + 3'(i_code[4]);
  assign o_valid_c = (ones_c == 3'd2);
  assign o_digit_c = code_to_digit(i_code);

endmodule

// File: rtl/decade_ring_check.sv
// Checker for the 2-of-5 decade counter: decode, shadow digit, sticky faults, wrap carry.
// Optional fault capture registers enabled by DECADE_RING_CHECK_CAPTURE_EN.
module decade_ring_check
  import decade_ring_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [CODE_W-1:0]  i_code,
  input  logic               i_clear,
  input  logic               i_advance,
  input  logic               i_err_ack,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_valid,
  output logic               o_carry,
  output logic               o_synced,
  output logic               o_code_err,
  output logic               o_seq_err,
  output logic [CODE_W-1:0]  o_err_code,
  output logic [DIGIT_W-1:0] o_err_expect
);

  state_e               state_q, state_d;
  logic [DIGIT_W-1:0]   exp_q, exp_d;
  logic                 last_adv_q;
  logic                 code_err_q, code_err_d;
  logic                 seq_err_q, seq_err_d;
  logic                 carry_d;
  logic                 adv_edge_c;
  logic [DIGIT_W-1:0]   dec_digit_c;
  logic                 dec_valid_c;

  two_of_five_decode u_decode (
    .i_code    (i_code),
    .o_digit_c (dec_digit_c),
    .o_valid_c (dec_valid_c)
  );

  assign adv_edge_c = i_advance & ~last_adv_q;

  // Next-state, shadow digit and fault flags
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    carry_d    = 1'b0;
    code_err_d = code_err_q;
    seq_err_d  = seq_err_q;

    if (i_clear) begin
      exp_d = '0;
    end else if (adv_edge_c) begin
      exp_d   = inc_mod10(exp_q);
      carry_d = (exp_q == DIGIT_W'(9));
    end

    case (state_q)
      UNSYNC: begin
        if (i_clear) state_d = TRACK;
      end
      TRACK: begin
        if (!dec_valid_c) begin
          code_err_d = 1'b1;
          state_d    = FAULT;
        end else if (dec_digit_c != exp_q) begin
          seq_err_d = 1'b1;
          state_d   = FAULT;
        end
      end
      FAULT: begin
        if (i_err_ack) begin
          code_err_d = 1'b0;
          seq_err_d  = 1'b0;
          state_d    = i_clear ? TRACK : UNSYNC;
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= UNSYNC;
      exp_q      <= '0;
      last_adv_q <= 1'b0;
      code_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
      o_digit    <= DIGIT_INVALID;
      o_valid    <= 1'b0;
      o_carry    <= 1'b0;
      o_synced   <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      last_adv_q <= i_advance;
      code_err_q <= code_err_d;
      seq_err_q  <= seq_err_d;
      o_digit    <= dec_digit_c;
      o_valid    <= dec_valid_c;
      o_carry    <= carry_d;
      o_synced   <= (state_d == TRACK);
    end
  end

  assign o_code_err = code_err_q;
  assign o_seq_err  = seq_err_q;

`ifdef DECADE_RING_CHECK_CAPTURE_EN
  logic [CODE_W-1:0]  err_code_q;
  logic [DIGIT_W-1:0] err_exp_q;

  // Snapshot on entry to FAULT; survives acknowledge
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      err_code_q <= '0;
      err_exp_q  <= '0;
    end else if ((state_q == TRACK) && (state_d == FAULT)) begin
      err_code_q <= i_code;
      err_exp_q  <= exp_q;
    end
  end

  assign o_err_code   = err_code_q;
  assign o_err_expect = err_exp_q;
`else
  assign o_err_code   = '0;
  assign o_err_expect = '0;
`endif

endmodule

// File: tb/tb_decade_ring_check.sv
// Randomized self-checking bench for decade_ring_check against a behavioural checker model.
module tb_decade_ring_check;

  logic       clk;
  logic       reset_n;
  logic [4:0] code;
  logic       clear;
  logic       advance;
  logic       err_ack;
  logic [3:0] digit;
  logic       valid;
  logic       carry;
  logic       synced;
  logic       code_err;
  logic       seq_err;
  logic [4:0] err_code;
  logic [3:0] err_expect;

  decade_ring_check dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_code       (code),
    .i_clear      (clear),
    .i_advance    (advance),
    .i_err_ack    (err_ack),
    .o_digit      (digit),
    .o_valid      (valid),
    .o_carry      (carry),
    .o_synced     (synced),
    .o_code_err   (code_err),
    .o_seq_err    (seq_err),
    .o_err_code   (err_code),
    .o_err_expect (err_expect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [4:0] code_tab [10] = '{5'b00011, 5'b10010, 5'b10001, 5'b01001, 5'b11000,
                                 5'b10100, 5'b01100, 5'b01010, 5'b00110, 5'b00101};

  // Reference model: 0=unsynced, 1=tracking, 2=faulted
  int   m_mode;
  int   m_exp;
  bit   m_last_adv;
  bit   m_code_err, m_seq_err, m_carry, m_valid, m_synced;
  int   m_digit;
  logic [4:0] m_cap_code;
  int   m_cap_exp;
  bit   cur_adv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_last_adv = 0;
    m_code_err = 0; m_seq_err = 0; m_carry = 0; m_valid = 0; m_synced = 0;
    m_digit = 15; m_cap_code = '0; m_cap_exp = 0;
  endtask

  task automatic model_step(input bit rst, input bit clr, input bit adv, input bit ack,
                            input logic [4:0] c);
    int  dec;
    bool_dummy: begin end
    if (!rst) begin
      model_reset();
      return;
    end
    dec = 15;
    for (int k = 0; k < 10; k++) if (code_tab[k] == c) dec = k;
    m_digit = dec;
    m_valid = (dec != 15);
    case (m_mode)
      0: if (clr) m_mode = 1;
      1: begin
        if (dec == 15) begin
          m_code_err = 1; m_mode = 2; m_cap_code = c; m_cap_exp = m_exp;
        end else if (dec != m_exp) begin
          m_seq_err = 1; m_mode = 2; m_cap_code = c; m_cap_exp = m_exp;
        end
      end
      default: if (ack) begin
        m_code_err = 0; m_seq_err = 0; m_mode = clr ? 1 : 0;
      end
    endcase
    m_carry = 0;
    if (clr) m_exp = 0;
    else if (adv && !m_last_adv) begin
      m_carry = (m_exp == 9);
      m_exp = (m_exp + 1) % 10;
    end
    m_last_adv = adv;
    m_synced = (m_mode == 1);
  endtask

  // One clock: drive at negedge (code follows the counter unless corrupted), check after posedge
  task automatic step(input bit rst, input bit clr, input bit adv, input bit ack,
                      input bit corrupt, input logic [4:0] bad);
    logic [4:0] c;
    @(negedge clk);
    c = corrupt ? bad : code_tab[m_exp];
    reset_n = rst; clear = clr; advance = adv; err_ack = ack; code = c;
    @(posedge clk);
    model_step(rst, clr, adv, ack, c);
    #1;
    check("digit", 32'(digit), 32'(m_digit));
    check("valid", 32'(valid), 32'(m_valid));
    check("carry", 32'(carry), 32'(m_carry));
    check("synced", 32'(synced), 32'(m_synced));
    check("code_err", 32'(code_err), 32'(m_code_err));
    check("seq_err", 32'(seq_err), 32'(m_seq_err));
`ifdef DECADE_RING_CHECK_CAPTURE_EN
    check("err_code", 32'(err_code), 32'(m_cap_code));
    check("err_expect", 32'(err_expect), 32'(m_cap_exp));
`else
    check("err_code", 32'(err_code), 32'(0));
    check("err_expect", 32'(err_expect), 32'(0));
`endif
  endtask

  task automatic goto_digit(input int n);
    for (int g = 0; g < 40 && m_exp != n; g++) begin
      step(1, 0, 1, 0, 0, '0);
      step(1, 0, 0, 0, 0, '0);
    end
  endtask

  int carries;

  initial begin
    reset_n = 0; clear = 0; advance = 0; err_ack = 0; code = '0;
    model_reset();
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    check("reset_digit", 32'(digit), 32'hF);
    step(1, 1, 0, 0, 0, '0);
    check("sync_after_clear", 32'(synced), 32'd1);
    step(1, 0, 0, 0, 0, '0);
    check("digit0_tracked", 32'(digit), 32'd0);

    // Ten advance edges: expect exactly one carry, on the return to 0
    carries = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 0, 0, '0);
      carries += int'(carry);
      step(1, 0, 0, 0, 0, '0);
      carries += int'(carry);
      check("count_digit", 32'(digit), 32'((i + 1) % 10));
    end
    check("carry_count", 32'(carries), 32'd1);

    goto_digit(3);
    step(1, 0, 0, 0, 1, 5'b11100);
    check("code_err_set", 32'(code_err), 32'd1);
    step(1, 1, 0, 1, 0, '0);
    check("ack_clear_sync", 32'(synced), 32'd1);
    step(1, 0, 0, 0, 0, '0);

    goto_digit(5);
    step(1, 0, 0, 0, 1, 5'b01010);
    check("seq_err_set", 32'(seq_err), 32'd1);
    step(1, 0, 0, 1, 0, '0);
    check("ack_alone_unsync", 32'(synced), 32'd0);
    step(1, 0, 0, 0, 0, '0);
    step(1, 1, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);

    goto_digit(9);
    step(1, 1, 1, 0, 0, '0);
    check("clear_no_carry", 32'(carry), 32'd0);
    step(1, 0, 1, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    goto_digit(6);
    step(0, 0, 0, 0, 0, '0);
    check("midreset_synced", 32'(synced), 32'd0);

    // Random traffic
    cur_adv = 0;
    for (int n = 0; n < 4000; n++) begin
      bit rst, clr, ack, cor;
      rst = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 24) == 0);
      ack = ($urandom_range(0, 9) == 0);
      cor = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) cur_adv = ~cur_adv;
      step(rst, clr, cur_adv, ack, cor, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
